instruc_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the 6-bit program counter and drives a synchronous instruction memory with a 1-cycle read latency.
- Buffers fetched 16-bit instruction words in a small prefetch queue and presents them to decode under a valid/stall handshake.
- Supports a redirect (jump/branch) that flushes all queued and in-flight fetches.

---
 rtl/mips_lite_pkg.sv | 33 +++
 rtl/instruc_fetch_if.sv | 27 ++
 rtl/instruc_fetch_fifo.sv | 66 ++++++
 rtl/instruc_fetch.sv | 77 +++++++
 tb/tb_instruc_fetch.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mips_lite_pkg.sv
// Shared constants and types for the mips_lite pipeline front end.
// Holds the instruction geometry, decode field positions and the fetch queue entry layout.
package mips_lite_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 6;

  // Instruction field positions consumed by decode
  localparam int unsigned OPC_HI     = 15;
  localparam int unsigned OPC_LO     = 13;
  localparam int unsigned ALUSRC_BIT = 12;
  localparam int unsigned REGWR_BIT  = 11;
  localparam int unsigned MEMWR_BIT  = 10;
  localparam int unsigned REGSRC_BIT = 9;
  localparam int unsigned RS_HI      = 8;
  localparam int unsigned RS_LO      = 6;
  localparam int unsigned RT_HI      = 5;
  localparam int unsigned RT_LO      = 3;
  localparam int unsigned RD_HI      = 2;
  localparam int unsigned RD_LO      = 0;
  localparam int unsigned ADDR_HI    = 5;
  localparam int unsigned ADDR_LO    = 0;

  typedef struct packed {
    logic [INSTR_W-1:0] word;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/instruc_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-side handshake.
// master = fetch stage, slave = memory/decode environment.
interface instruc_fetch_if;
  import mips_lite_pkg::*;

  logic               run;
  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_addr;
  logic               stall;
  logic [INSTR_W-1:0] instruc;
  logic [PC_W-1:0]    instruc_pc;
  logic               instruc_valid;

  modport master (
    input  run, imem_rdata, redirect, redirect_addr, stall,
    output imem_en, imem_addr, instruc, instruc_pc, instruc_valid
  );

  modport slave (
    output run, imem_rdata, redirect, redirect_addr, stall,
    input  imem_en, imem_addr, instruc, instruc_pc, instruc_valid
  );

endinterface

// File: rtl/instruc_fetch_fifo.sv
// Synchronous prefetch FIFO with flush; DEPTH must be a power of two (pointers wrap naturally).
module fetch_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instruc_fetch.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency memory reads and
// feeds decode from a prefetch queue; redirect flushes queued and in-flight work.
module instruc_fetch
  import mips_lite_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  instruc_fetch_if.master bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic             issue, push, pop;
  logic [CNT_W-1:0] count, occupancy;
  logic             empty, full;
  fetch_entry_t     push_entry, head;

  always_comb begin
    occupancy = count + CNT_W'(inflight_q);
    // Gated by rst so the request drops the moment reset asserts, not at the next edge
    issue         = ~rst & bus.run & ~bus.redirect & (occupancy < CNT_W'(FIFO_DEPTH));
    push          = inflight_q & ~bus.redirect;
    pop           = ~empty & ~bus.stall & ~bus.redirect;
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (bus.redirect) begin
      pc_d = bus.redirect_addr;
    end else if (issue) begin
      pc_d          = pc_inc(pc_q);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push_entry = '{word: bus.imem_rdata, pc: inflight_pc_q};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.redirect),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full)
  );

  assign bus.imem_en       = issue;
  assign bus.imem_addr     = pc_q;
  assign bus.instruc_valid = ~empty;
  assign bus.instruc       = empty ? '0 : head.word;
  assign bus.instruc_pc    = empty ? '0 : head.pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_instruc_fetch.sv
// Self-checking bench for instruc_fetch: directed scenarios then random traffic,
// checked against a queue-of-issued-fetches reference model.
module tb_instruc_fetch;
  import mips_lite_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruc_fetch_if bus();

  instruc_fetch #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [64];

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
  end

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: every issued fetch is an entry until decode takes it;
  // an entry becomes visible one edge after it was issued.
  typedef struct {
    logic [5:0] pc;
    bit         ready;
  } ent_t;

  ent_t       pend[$];
  logic [5:0] m_pc;

  function automatic bit exp_valid();
    return (pend.size() > 0) && pend[0].ready;
  endfunction

  function automatic bit exp_en();
    return bus.run && !bus.redirect && (pend.size() < 4);
  endfunction

  task automatic model_reset();
    pend.delete();
    m_pc = 6'd0;
  endtask

  task automatic step();
    bit v;
    bit e;
    @(negedge clk);
    v = exp_valid();
    e = exp_en();
    chk("imem_en", 32'(bus.imem_en), 32'(e));
    chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    chk("instruc_valid", 32'(bus.instruc_valid), 32'(v));
    if (v) begin
      chk("instruc", 32'(bus.instruc), 32'(mem[pend[0].pc]));
      chk("instruc_pc", 32'(bus.instruc_pc), 32'(pend[0].pc));
    end
    if (bus.redirect) begin
      pend.delete();
      m_pc = bus.redirect_addr;
    end else begin
      if (v && !bus.stall) void'(pend.pop_front());
      foreach (pend[k]) pend[k].ready = 1'b1;
      if (e) begin
        pend.push_back('{pc: m_pc, ready: 1'b0});
        m_pc = m_pc + 6'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_imem_en", 32'(bus.imem_en), 32'd0);
    chk("rst_valid", 32'(bus.instruc_valid), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_redirect(input logic [5:0] a);
    bus.redirect      = 1'b1;
    bus.redirect_addr = a;
    step();
    bus.redirect      = 1'b0;
  endtask

  initial begin
    for (int unsigned i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
    rst               = 1'b1;
    bus.run           = 1'b0;
    bus.stall         = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = 6'd0;
    bus.imem_rdata    = 16'h0;
    model_reset();

    @(posedge clk);
    #1;
    chk("reset_imem_en", 32'(bus.imem_en), 32'd0);
    chk("reset_valid", 32'(bus.instruc_valid), 32'd0);
    chk("reset_instruc", 32'(bus.instruc), 32'd0);
    chk("reset_instruc_pc", 32'(bus.instruc_pc), 32'd0);
    chk("reset_addr", 32'(bus.imem_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming from 0, one word per cycle
    bus.run = 1'b1;
    repeat (10) step();

    // Stall fills exactly four entries, head holds
    bus.stall = 1'b1;
    do_redirect(6'd0);
    repeat (10) step();
    chk("stall_head", 32'(bus.instruc), 32'hA000);
    chk("stall_no_issue", 32'(bus.imem_en), 32'd0);
    bus.stall = 1'b0;
    repeat (10) step();

    // Redirect with three queued and one in flight
    bus.stall = 1'b1;
    do_redirect(6'd0);
    repeat (4) step();
    do_redirect(6'd40);
    chk("redir_valid", 32'(bus.instruc_valid), 32'd0);
    chk("redir_addr", 32'(bus.imem_addr), 32'd40);
    bus.stall = 1'b0;
    repeat (8) step();

    // Back-to-back redirects: last wins
    do_redirect(6'd20);
    do_redirect(6'd50);
    repeat (6) step();

    // PC wrap 62,63,0,1
    do_redirect(6'd60);
    repeat (10) step();

    // Asynchronous reset with a full, stalled queue
    bus.stall = 1'b1;
    do_redirect(6'd5);
    repeat (6) step();
    async_reset();
    bus.stall = 1'b0;
    repeat (6) step();

    // run=0 with one request in flight
    do_redirect(6'd10);
    step();
    bus.run = 1'b0;
    repeat (5) step();
    chk("run0_pc_hold", 32'(bus.imem_addr), 32'd11);
    chk("run0_drained", 32'(bus.instruc_valid), 32'd0);

    // Random traffic with random memory contents
    for (int unsigned i = 0; i < 64; i++) mem[i] = 16'($urandom);
    for (int unsigned c = 0; c < 800; c++) begin
      bus.run           = ($urandom_range(0, 7) != 0);
      bus.stall         = ($urandom_range(0, 2) == 0);
      bus.redirect      = ($urandom_range(0, 15) == 0);
      bus.redirect_addr = 6'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        bus.redirect = 1'b0;
        async_reset();
      end else begin
        step();
      end
    end
    bus.redirect = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
